// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and widths for the instruction-fetch sequencer and its fetch buffer.
package inst_fetch_ctrl_pkg;
    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_ctrl_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; the head is read from
// registered entries, so nothing on the read side is combinational from the write data.
module fetch_fifo
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  fetch_entry_t                     push_data,
    input  logic                             pop,
    input  logic                             flush,
    output fetch_entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    fetch_entry_t     entries [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = entries[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push_ok && !flush && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= push_data;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures memory words into a small
// buffer feeding decode, and handles redirects and range/alignment faults.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                MEM_BYTES = 512,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                DEPTH     = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INSTR_BYTES);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] fpc_reg, fpc_next;
    logic              fault_reg, fault_next;
    logic [ADDR_W-1:0] fault_pc_reg, fault_pc_next;

    logic              push, pop, flush, legal;
    logic              fifo_full, fifo_empty;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    fetch_entry_t      push_data, head;

    assign legal     = (fpc_reg[1:0] == 2'b00) && (fpc_reg <= LAST_PC);
    assign pop       = out_valid & out_ready;
    assign push_data = '{pc: fpc_reg, instr: imem_rdata};

    always_comb begin
        state_next    = state_reg;
        fpc_next      = fpc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        push          = 1'b0;
        flush         = 1'b0;
        if (redirect_valid) begin
            // Redirect beats everything: any pop this cycle is still consumed by decode.
            flush      = 1'b1;
            fpc_next   = redirect_pc;
            state_next = RUN;
            fault_next = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (!legal) begin
                        state_next    = FAULT;
                        fault_next    = 1'b1;
                        fault_pc_next = fpc_reg;
                    end else if (!fifo_full || pop) begin
                        push     = 1'b1;
                        fpc_next = fpc_reg + ADDR_W'(INSTR_BYTES);
                    end
                end
                FAULT: ;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            fpc_reg      <= RESET_PC;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fpc_reg      <= fpc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (fifo_count <= ($clog2(DEPTH+1))'(DEPTH));
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign imem_addr = fpc_reg;
    assign out_valid = ~fifo_empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign fault     = fault_reg;
    assign fault_pc  = fault_pc_reg;
endmodule
